// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory port B: parses 'W'/'R' burst commands,
// packs bytes into full-word writes and serialises read words back out LSB first.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  en_b,
  output logic                  we_b,
  output logic [3:0]            wstrb_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] din_b,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [3:0] {
    StIdle, StAddr0, StAddr1, StCnt0, StCnt1, StWdata,
    StWrite, StRreq, StRwait, StRsend, StAck
  } state_e;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] AckByte = 8'h4B;

  state_e                  state_q, state_d;
  logic                    is_read_q, is_read_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0]   din_b_q, din_b_d;
  logic                    err_q, err_d;
  logic                    rx_fire, tx_fire;

  always_comb begin
    rx_ready = (state_q == StIdle) || (state_q == StAddr0) || (state_q == StAddr1) ||
               (state_q == StCnt0) || (state_q == StCnt1) || (state_q == StWdata);
    tx_valid = (state_q == StRsend) || (state_q == StAck);
    tx_data  = (state_q == StAck) ? AckByte :
               (state_q == StRsend) ? word_q[7:0] : 8'h00;
    en_b     = (state_q == StWrite) || (state_q == StRreq);
    we_b     = (state_q == StWrite);
    wstrb_b  = (state_q == StWrite) ? 4'hF : 4'h0;
    busy     = (state_q != StIdle);
    rx_fire  = rx_valid && rx_ready;
    tx_fire  = tx_valid && tx_ready;
  end

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    addr_b_d  = addr_b_q;
    din_b_d   = din_b_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (rx_data == OpWrite || rx_data == OpRead) begin
            is_read_d = (rx_data == OpRead);
            state_d   = StAddr0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddr0: begin
        if (rx_fire) begin
          for (int i = 0; i < 8 && i < ADDR_WIDTH; i++) addr_d[i] = rx_data[i];
          state_d = StAddr1;
        end
      end
      StAddr1: begin
        if (rx_fire) begin
          // Address bits above ADDR_WIDTH are dropped.
          for (int i = 8; i < 16 && i < ADDR_WIDTH; i++) addr_d[i] = rx_data[i-8];
          state_d = StCnt0;
        end
      end
      StCnt0: begin
        if (rx_fire) begin
          cnt_d[7:0] = rx_data;
          state_d    = StCnt1;
        end
      end
      StCnt1: begin
        if (rx_fire) begin
          cnt_d[15:8] = rx_data;
          idx_d       = 2'd0;
          if (cnt_d == 16'd0) state_d = is_read_q ? StIdle : StAck;
          else                state_d = is_read_q ? StRreq : StWdata;
        end
      end
      StWdata: begin
        if (rx_fire) begin
          word_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_d == 16'd0) ? StAck : StWdata;
      end
      StRreq: state_d = StRwait;
      StRwait: begin
        word_d  = dout_b;
        idx_d   = 2'd0;
        state_d = StRsend;
      end
      StRsend: begin
        if (tx_fire) begin
          word_d = word_q >> 8;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_d == 16'd0) ? StIdle : StRreq;
          end
        end
      end
      StAck: if (tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Port B address/data only change when a strobe cycle is about to start.
    if (state_d == StWrite) din_b_d = word_d;
    if (state_d == StWrite || state_d == StRreq) addr_b_d = addr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      addr_b_q  <= '0;
      din_b_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      addr_b_q  <= addr_b_d;
      din_b_q   <= din_b_d;
      err_q     <= err_d;
    end
  end

  assign addr_b = addr_b_q;
  assign din_b  = din_b_q;
  assign err    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected port B ops, tx bytes and
// err pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          en_b, we_b;
  logic [3:0]    wstrb_b;
  logic [AW-1:0] addr_b;
  logic [31:0]   din_b;
  logic [31:0]   dout_b = 32'h0;
  logic          busy, err;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .en_b(en_b), .we_b(we_b),
    .wstrb_b(wstrb_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } mop_t;

  mop_t       mop_q[$];
  logic [7:0] tx_q[$];
  int         err_exp = 0;
  int         pass_cnt = 0;
  int         chk_cnt = 0;
  bit         rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Port B memory model with one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      else      dout_b <= mem[addr_b];
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic       err_prev = 1'b0;
  mop_t       m;
  logic [7:0] tb;
  always @(negedge clk) begin
    if (rst) begin
      pend     = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (pend) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(pend_data));
      end
      pend      = tx_valid && !tx_ready;
      pend_data = tx_data;
      if (en_b) begin
        chk("mem_op_expected", 32'(mop_q.size() > 0), 32'd1);
        if (mop_q.size() > 0) begin
          m = mop_q.pop_front();
          chk("mem_we", 32'(we_b), 32'(m.we));
          chk("mem_addr", 32'(addr_b), 32'(m.addr));
          chk("mem_wstrb", 32'(wstrb_b), m.we ? 32'hF : 32'h0);
          if (m.we) chk("mem_din", din_b, m.din);
        end
      end
      if (tx_valid && tx_ready) begin
        chk("tx_expected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) begin
          tb = tx_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(tb));
        end
      end
      if (err) begin
        chk("err_expected", 32'(err_exp > 0), 32'd1);
        if (err_exp > 0) begin
          err_exp--;
          chk("err_busy", 32'(busy), 32'd0);
          chk("err_one_cycle", 32'(err_prev), 32'd0);
        end
      end
      err_prev = err;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] c);
    send_byte(op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || mop_q.size() != 0 || tx_q.size() != 0 || err_exp != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en_b", 32'(en_b), 32'd0);
    chk("rst_we_b", 32'(we_b), 32'd0);
    chk("rst_wstrb", 32'(wstrb_b), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd0);
    chk("rst_din_b", din_b, 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rx_ready", 32'(rx_ready), 32'd1);

    // Two-word write burst
    mop_q.push_back('{we: 1'b1, addr: 10'h100, din: 32'h12345678});
    mop_q.push_back('{we: 1'b1, addr: 10'h101, din: 32'hDEADBEEF});
    tx_q.push_back(8'h4B);
    send_frame(8'h57, 16'h0100, 16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    wait_done("write_burst");

    // Read back
    mop_q.push_back('{we: 1'b0, addr: 10'h100, din: 32'h0});
    mop_q.push_back('{we: 1'b0, addr: 10'h101, din: 32'h0});
    push_tx_word(32'h12345678);
    push_tx_word(32'hDEADBEEF);
    send_frame(8'h52, 16'h0100, 16'd2);
    wait_done("read_burst");

    // Address wrap
    mop_q.push_back('{we: 1'b1, addr: 10'h3FF, din: 32'hDDCCBBAA});
    mop_q.push_back('{we: 1'b1, addr: 10'h000, din: 32'h04030201});
    tx_q.push_back(8'h4B);
    send_frame(8'h57, 16'h03FF, 16'd2);
    send_word(32'hDDCCBBAA);
    send_word(32'h04030201);
    wait_done("wrap_write");

    // Wrapped read back under random backpressure
    rand_ready = 1'b1;
    mop_q.push_back('{we: 1'b0, addr: 10'h3FF, din: 32'h0});
    mop_q.push_back('{we: 1'b0, addr: 10'h000, din: 32'h0});
    push_tx_word(32'hDDCCBBAA);
    push_tx_word(32'h04030201);
    send_frame(8'h52, 16'h03FF, 16'd2);
    wait_done("wrap_read_bp");
    rand_ready = 1'b0;

    // Zero counts
    tx_q.push_back(8'h4B);
    send_frame(8'h57, 16'h0010, 16'd0);
    wait_done("zero_write");
    send_frame(8'h52, 16'h0010, 16'd0);
    wait_done("zero_read");
    chk("zero_read_idle", 32'(busy), 32'd0);

    // Bad opcode, then a valid command
    err_exp = 1;
    send_byte(8'h41);
    #1 chk("bad_op_busy", 32'(busy), 32'd0);
    wait_done("bad_op");
    mop_q.push_back('{we: 1'b0, addr: 10'h100, din: 32'h0});
    push_tx_word(32'h12345678);
    send_frame(8'h52, 16'h0100, 16'd1);
    wait_done("after_bad_op");

    // Reset mid-write after two data bytes
    send_frame(8'h57, 16'h0000, 16'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_en_b", 32'(en_b), 32'd0);
    chk("midrst_addr_b", 32'(addr_b), 32'd0);
    chk("midrst_din_b", din_b, 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    mop_q.push_back('{we: 1'b1, addr: 10'h020, din: 32'h44332211});
    tx_q.push_back(8'h4B);
    send_frame(8'h57, 16'h0020, 16'd1);
    send_word(32'h44332211);
    wait_done("after_reset");
    chk("mem_0_untouched", mem[0], 32'h04030201);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
